// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg: shared types and constants for the SPI display receiver.
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int DATA_BITS_DEFAULT = 8;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_rx_fifo.sv
// ============================================================================
// spi_rx_fifo: DEPTH-entry receive FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle. Rev 1.0
// ============================================================================
`default_nettype none

module spi_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_wr_en  = push & (~full | pop);
    assign w_rd_en  = pop & ~empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_display_receiver.sv
// ============================================================================
// spi_display_receiver: SPI slave for display command/data words.
// Macro SPI_RX_FIFO_EN selects a FIFO buffer instead of one holding register.
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_display_receiver
    import spi_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs,
    input  logic                 dc,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_dc,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overflow,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int               CNT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_BITS - 1);

    if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("spi_display_receiver: SYNC_STAGES must be >=2, FIFO_DEPTH a power of two >=2");
    end

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_dc_sync, r_live;
    logic                   r_sclk_prev, r_armed;
    logic                   w_sclk_rise, w_mosi_s, w_cs_s, w_dc_s;

    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_dc_s      = r_dc_sync[SYNC_STAGES-1];
    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;

    // r_live marks when the cs chain holds a real pin sample rather than its
    // reset value; only a genuine cs-high arms the receiver after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_dc_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_live      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], dc};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_live      <= {r_live[SYNC_STAGES-2:0], 1'b1};
            r_armed     <= r_armed | (r_live[SYNC_STAGES-1] & w_cs_s);
        end
    end

    spi_state_e           r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_push;
    logic [DATA_BITS:0]   r_push_data;
    logic                 r_frame_err;

    assign w_shift_next = {r_shift[DATA_BITS-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && !w_cs_s) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_s) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= (r_bit_cnt != '0);
                        r_bit_cnt   <= '0;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt   <= '0;
                            r_push      <= 1'b1;
                            r_push_data <= {w_dc_s, w_shift_next};
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic [DATA_BITS:0] w_head;
    logic               w_full;
    logic               w_pop;
    logic               r_overflow;

    assign w_pop = rx_valid & rx_ready;

`ifdef SPI_RX_FIFO_EN
    logic w_empty;

    spi_rx_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_push),
        .push_data (r_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign rx_valid = ~w_empty;
`else
    logic [DATA_BITS:0] r_hold;
    logic               r_hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (r_push && (!r_hold_valid || w_pop)) begin
            r_hold       <= r_push_data;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_head   = r_hold;
    assign w_full   = r_hold_valid;
    assign rx_valid = r_hold_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign rx_data   = w_head[DATA_BITS-1:0];
    assign rx_dc     = w_head[DATA_BITS];
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_spi_display_receiver.sv
// ============================================================================
// tb_spi_display_receiver: self-checking bench for spi_display_receiver.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_display_receiver;
    import spi_pkg::*;

    localparam int DB = 8;
    localparam int FD = 4;
    localparam int SS = 2;
`ifdef SPI_RX_FIFO_EN
    localparam int DEPTH = FD;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n, sclk, mosi, cs, dc, rx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_dc, rx_valid, overflow, frame_err, busy;

    int errors = 0;
    int checks = 0;
    int fe_count = 0;
    int busy_seen = 0;
    logic [DB:0] got[$];
    logic [DB:0] exp_q[$];

    always #5 clk = ~clk;

    spi_display_receiver #(
        .DATA_BITS   (DB),
        .FIFO_DEPTH  (FD),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .dc        (dc),
        .rx_data   (rx_data),
        .rx_dc     (rx_dc),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overflow  (overflow),
        .frame_err (frame_err),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: collects popped entries, counts frame_err pulses, checks head stability.
    logic        prev_hold = 1'b0;
    logic        prev_fe = 1'b0;
    logic [DB:0] prev_head = '0;
    always @(negedge clk) begin
        if (frame_err) begin
            fe_count++;
            check("frame_err_pulse_width", {31'd0, prev_fe}, 32'd0);
        end
        if (prev_hold && rx_valid) check("head_stable", {rx_dc, rx_data}, prev_head);
        if (rx_valid && rx_ready) got.push_back({rx_dc, rx_data});
        if (busy) busy_seen++;
        prev_hold = rx_valid & ~rx_ready;
        prev_head = {rx_dc, rx_data};
        prev_fe   = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [31:0] data, input int n, input logic d);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = data[i];
            dc   = d;
            tick(3);
            sclk = 1'b1;
            tick(3);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        tick(2);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick(DEPTH + 6);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(name, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [23:0] words;
        logic [2:0]  dcs;
        int          nwords;
        int          tail;
        logic [7:0]  tail_val;
        int          exp_entries;
        int          exp_fe;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        logic [7:0] w;
        logic       d;
        int         fe0, lat, n, tl;
        logic       ovf_model;

        vecs[0] = '{words: 24'hA50000, dcs: 3'b100, nwords: 1, tail: 0, tail_val: 8'h00, exp_entries: 1, exp_fe: 0};
        vecs[1] = '{words: 24'h2A007F, dcs: 3'b011, nwords: 3, tail: 0, tail_val: 8'h00, exp_entries: 3, exp_fe: 0};
        vecs[2] = '{words: 24'h000000, dcs: 3'b000, nwords: 0, tail: 3, tail_val: 8'h05, exp_entries: 0, exp_fe: 1};
        vecs[3] = '{words: 24'h3C0000, dcs: 3'b000, nwords: 1, tail: 0, tail_val: 8'h00, exp_entries: 1, exp_fe: 0};
        vecs[4] = '{words: 24'hFF8000, dcs: 3'b010, nwords: 2, tail: 7, tail_val: 8'h55, exp_entries: 2, exp_fe: 1};

        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = DC_CMD; rx_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("reset_outputs", {19'd0, rx_data, rx_dc, rx_valid, overflow, frame_err, busy}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Streaming frames with the consumer always ready.
        for (int v = 0; v < NV; v++) begin
            fe0 = fe_count;
            rx_ready = 1'b1;
            cs_begin();
            for (int i = 0; i < vecs[v].nwords; i++) begin
                w = vecs[v].words[23-8*i -: 8];
                d = vecs[v].dcs[2-i];
                send_bits({24'd0, w}, 8, d);
                exp_q.push_back({d, w});
            end
            if (vecs[v].tail > 0) send_bits({24'd0, vecs[v].tail_val}, vecs[v].tail, DC_CMD);
            cs_end();
            tick(2);
            rx_ready = 1'b0;
            check("vec_entries", got.size(), vecs[v].exp_entries);
            compare_q("vec_data");
            check("vec_frame_err", fe_count - fe0, vecs[v].exp_fe);
            check("vec_overflow", {31'd0, overflow}, 32'd0);
        end

        // Pin edge to rx_valid latency with an empty buffer.
        cs_begin();
        send_bits(32'h4B >> 1, 7, DC_DATA);
        mosi = 1'b1; dc = DC_DATA;
        tick(3);
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, SS + 2);
        tick(1);
        sclk = 1'b0;
        cs_end();
        exp_q.push_back({DC_DATA, 8'h4B});
        drain();
        compare_q("latency_data");

        // sclk activity with cs high must be ignored.
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'($urandom_range(0, 1));
            tick(3); sclk = 1'b1; tick(3); sclk = 1'b0;
        end
        tick(6);
        check("idle_sclk_valid", {31'd0, rx_valid}, 32'd0);
        check("idle_sclk_busy", busy_seen, 0);
        compare_q("idle_sclk_entries");

        // Push coinciding with pop on a full buffer must be accepted.
        cs_begin();
        for (int i = 0; i < DEPTH; i++) begin
            send_bits(32'h10 + i, 8, 1'(i % 2));
            exp_q.push_back({1'(i % 2), 8'(8'h10 + i)});
        end
        send_bits(32'hEE >> 1, 7, DC_DATA);
        mosi = 1'b0; dc = DC_DATA;
        tick(3);
        sclk = 1'b1;
        tick(SS + 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        sclk = 1'b0;
        cs_end();
        exp_q.push_back({DC_DATA, 8'hEE});
        check("pushpop_full_overflow", {31'd0, overflow}, 32'd0);
        drain();
        compare_q("pushpop_full_data");

        // Five words into a stalled consumer.
        cs_begin();
        for (int i = 1; i <= 5; i++) begin
            send_bits(i, 8, DC_DATA);
            if (i <= DEPTH) exp_q.push_back({DC_DATA, 8'(i)});
        end
        cs_end();
        check("overflow_set", {31'd0, overflow}, 32'd1);
        drain();
        compare_q("overflow_data");
        check("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of a word, then restart only after cs high->low.
        cs_begin();
        send_bits(32'hFF, 5, DC_DATA);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        check("midreset_outputs", {19'd0, rx_data, rx_dc, rx_valid, overflow, frame_err, busy}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        busy_seen = 0;
        fe0 = fe_count;
        tick(4);
        send_bits(32'hFF, 8, DC_DATA);
        tick(4);
        check("post_reset_cs_low_busy", busy_seen, 0);
        compare_q("post_reset_cs_low_entries");
        cs = 1'b1;
        tick(6);
        cs_begin();
        send_bits(32'h81, 8, DC_DATA);
        cs_end();
        exp_q.push_back({DC_DATA, 8'h81});
        drain();
        compare_q("post_reset_data");
        check("post_reset_frame_err", fe_count - fe0, 0);
        check("post_reset_overflow", {31'd0, overflow}, 32'd0);

        // Random frames against a queue model with a stalled consumer.
        ovf_model = 1'b0;
        for (int f = 0; f < 6; f++) begin
            n  = $urandom_range(0, DEPTH + 2);
            tl = $urandom_range(0, DB - 1);
            fe0 = fe_count;
            cs_begin();
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom_range(0, 255));
                d = 1'($urandom_range(0, 1));
                send_bits({24'd0, w}, 8, d);
                if (i < DEPTH) exp_q.push_back({d, w});
            end
            if (n > DEPTH) ovf_model = 1'b1;
            if (tl > 0) send_bits($urandom, tl, DC_CMD);
            cs_end();
            check("rand_overflow", {31'd0, overflow}, {31'd0, ovf_model});
            check("rand_frame_err", fe_count - fe0, (tl != 0) ? 1 : 0);
            drain();
            compare_q("rand_data");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
